// File: rtl/grf_wb_pkg.sv
// grf_wb_pkg: shared widths, FIFO entry type and register-zero constant for the GRF write-back arbiter
package grf_wb_pkg;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;
    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [WB_ADDR_W-1:0] wa;
        logic [WB_DATA_W-1:0] wd;
        logic [WB_DATA_W-1:0] pc;
        logic                 live;
    } wb_entry_t;
endpackage

// File: rtl/grf_wb_fifo.sv
// grf_wb_fifo: auxiliary write FIFO with kill-by-address and live-entry lookup on two ports
module grf_wb_fifo
    import grf_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  wb_entry_t            i_push_e,
    input  logic                 i_pop,
    input  logic                 i_kill,
    input  logic [WB_ADDR_W-1:0] i_kill_wa,
    input  logic [WB_ADDR_W-1:0] i_ra1,
    input  logic [WB_ADDR_W-1:0] i_ra2,
    output wb_entry_t            o_head,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_hit1,
    output logic                 o_hit2
);
    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // Kill older matches first, retire the popped slot, then write the new (younger, live) entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i].live <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (i_kill && r_mem[i].wa == i_kill_wa) r_mem[i].live <= 1'b0;
            if (i_pop) begin
                r_mem[r_rd].live <= 1'b0;
                r_rd             <= r_rd + 1'b1;
            end
            if (i_push) begin
                r_mem[r_wr] <= i_push_e;
                r_wr        <= r_wr + 1'b1;
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    // Only occupied entries can be live, so a plain scan of all slots is enough
    always_comb begin
        o_hit1 = 1'b0;
        o_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            o_hit1 = o_hit1 | (r_mem[i].live && r_mem[i].wa == i_ra1 && i_ra1 != REG_ZERO);
            o_hit2 = o_hit2 | (r_mem[i].live && r_mem[i].wa == i_ra2 && i_ra2 != REG_ZERO);
        end
    end
endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: merges pipeline and buffered auxiliary write-backs onto the single GRF write port
// Optional commit trace enabled by defining WB_TRACE_EN.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_wa,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic [DATA_W-1:0] pipe_pc,
    input  logic              aux_valid,
    output logic              aux_ready,
    input  logic [ADDR_W-1:0] aux_wa,
    input  logic [DATA_W-1:0] aux_wd,
    input  logic [DATA_W-1:0] aux_pc,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_wa,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc,
    input  logic [ADDR_W-1:0] q_ra1,
    input  logic [ADDR_W-1:0] q_ra2,
    output logic              q_hit1,
    output logic              q_hit2,
    output logic [CNT_W-1:0]  count
);
    wb_entry_t w_head;
    wb_entry_t w_push_e;
    logic      w_pipe_eff;
    logic      w_nonempty;
    logic      w_aux_sel;
    logic      w_push;
    logic      w_pop;
    logic      w_hit1;
    logic      w_hit2;

    assign w_pipe_eff = pipe_we && pipe_wa != REG_ZERO;
    assign w_nonempty = count != '0;
    assign aux_ready  = !rst && count != CNT_W'(DEPTH);
    assign w_push     = aux_valid && aux_ready && aux_wa != REG_ZERO;
    assign w_push_e   = '{wa: aux_wa, wd: aux_wd, pc: aux_pc, live: 1'b1};
    assign w_aux_sel  = w_nonempty && w_head.live && !w_pipe_eff;
    assign w_pop      = !rst && w_nonempty && (!w_head.live || !w_pipe_eff);

    // Pipeline always wins the port; a live head drains only into idle cycles
    always_comb begin
        grf_we = !rst && (w_pipe_eff || w_aux_sel);
        grf_wa = !grf_we ? '0 : w_pipe_eff ? pipe_wa : w_head.wa;
        grf_wd = !grf_we ? '0 : w_pipe_eff ? pipe_wd : w_head.wd;
        grf_pc = !grf_we ? '0 : w_pipe_eff ? pipe_pc : w_head.pc;
        q_hit1 = !rst && w_hit1;
        q_hit2 = !rst && w_hit2;
    end

    grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_push_e  (w_push_e),
        .i_pop     (w_pop),
        .i_kill    (w_pipe_eff && !rst),
        .i_kill_wa (pipe_wa),
        .i_ra1     (q_ra1),
        .i_ra2     (q_ra2),
        .o_head    (w_head),
        .o_count   (count),
        .o_hit1    (w_hit1),
        .o_hit2    (w_hit2)
    );

`ifdef WB_TRACE_EN
    // Canonical commit trace covering both write sources
    always @(posedge clk) begin
        if (!rst && grf_we) $display("@%h: $%d <= %h", grf_pc, grf_wa, grf_wd);
    end
`endif
endmodule
